conveyor_read_dispatch: RTL and testbench
=========================================

# conveyor_read_dispatch

Memory-side producer for the conveyors: accepts read requests tagged with a target conveyor (0 = main, 1 = interrupt) and slot index, issues them in order on a valid/ready memory bus, and returns each response as a slot write (finished flag, fault code, data) addressed to the tagged conveyor slot. It decouples read issue from result arrival so multiple reads can be in flight while consumers stall on unfinished slots.

## Interface
Parameters:
- WORD_WIDTH, 32, data and address width
- CONVEYOR_ADDR_WIDTH, 4, slot index width
- TAG_FIFO_ADDR_WIDTH, 2, log2 of max outstanding reads (DEPTH = 4)
- FAULT_ADDR_WIDTH, 3, fault code width

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; asserted low clears all state immediately
- req_valid  in  1  read request present
- req_ready  out  1  request accepted this cycle when both high
- req_addr  in  WORD_WIDTH  read address
- req_conveyor  in  1  target conveyor
- req_slot  in  CONVEYOR_ADDR_WIDTH  target slot
- mem_req_valid  out  1  bus read request
- mem_req_ready  in  1  bus accepts request
- mem_req_addr  out  WORD_WIDTH  bus address
- mem_resp_valid  in  1  bus response (in order, no backpressure)
- mem_resp_data  in  WORD_WIDTH  response data
- mem_resp_error  in  1  bus error on this response
- wr_valid  out  1  slot write strobe, one cycle
- wr_conveyor  out  1  target conveyor of write
- wr_slot  out  CONVEYOR_ADDR_WIDTH  target slot
- wr_word  out  1+FAULT_ADDR_WIDTH+WORD_WIDTH  {finished=1, fault, data}
- outstanding  out  TAG_FIFO_ADDR_WIDTH+1  reads accepted but not yet written back
- protocol_error  out  1  sticky: response with no outstanding read

## Operation
- Issue register: holds one address; mem_req_valid is its valid bit; cleared on mem_req handshake unless refilled same cycle.
- Tag FIFO (DEPTH entries of {conveyor, slot}): pushed on req handshake, popped on mem_resp_valid.
- req_ready = (outstanding < DEPTH) && (!mem_req_valid || mem_req_ready). Combinational; no dependence on req_valid.
- Response with FIFO non-empty: register wr_valid=1, wr_conveyor/wr_slot = FIFO head, wr_word = {1, F_NONE, mem_resp_data}; if mem_resp_error, wr_word = {1, F_BUS, 0}. Pop FIFO.
- Response with FIFO empty: no write, no pop, set protocol_error (cleared only by reset).
- outstanding: +1 on push, -1 on pop, unchanged on simultaneous push and pop; never exceeds DEPTH.
- FIFO pointers wrap modulo DEPTH; full/empty from outstanding, not pointer compare.
- Reset (any time, including mid-transfer): outstanding=0, pointers=0, mem_req_valid=0, mem_req_addr=0, wr_valid=0, wr_conveyor=0, wr_slot=0, wr_word=0, protocol_error=0. In-flight reads are dropped; later responses set protocol_error.

## Timing
- req handshake cycle N -> mem_req_valid high at N+1 with addr; held stable until mem_req_ready.
- mem_resp_valid at cycle M -> wr_valid high at M+1 for exactly one cycle.
- Back-to-back: one request per cycle sustained when mem_req_ready stays high and FIFO not full.
- Response may coincide with new request accept; both take effect (outstanding unchanged).
- Full FIFO with response in same cycle: req_ready still 0 (computed from registered count); accept resumes next cycle.

## Structure
- F_NONE, F_BUS in the shared faults include (add F_BUS if absent); slot word layout {finished, fault, data} shared with conveyor control.
- One sub-module: tag_fifo (parameterized sync FIFO with count, async active-low reset).

## Test plan
- Single read: req addr 0x100, conveyor 0, slot 15; resp data 0xDEADBEEF two cycles after issue -> wr_valid one cycle later, slot 15, conveyor 0, wr_word {1, F_NONE, 0xDEADBEEF}; outstanding 1 then 0.
- Fill: 4 requests with mem_resp idle -> outstanding=4, req_ready=0; one response -> wr slot of first request, req_ready=1 next cycle.
- Bus stall: mem_req_ready low 3 cycles -> mem_req_addr stable, req_ready=0, no second issue until handshake.
- Error: mem_resp_error=1 -> wr_word {1, F_BUS, 0}, correct slot/conveyor, FIFO popped.
- Spurious: mem_resp_valid with outstanding=0 -> no wr_valid, protocol_error=1 held until reset.
- Reset mid-operation: 3 outstanding, assert reset low asynchronously -> all outputs 0 immediately; release, response arrives -> protocol_error=1, no write.

Source files
------------

// File: rtl/conveyor_read_dispatch_pkg.sv
// Shared types for the conveyor read dispatcher: fault codes and default widths.
// The slot word layout {finished, fault, data} is common with conveyor control.
package conveyor_read_dispatch_pkg;

  localparam int WORD_WIDTH_DEF          = 32;
  localparam int CONVEYOR_ADDR_WIDTH_DEF = 4;
  localparam int TAG_FIFO_ADDR_WIDTH_DEF = 2;
  localparam int FAULT_ADDR_WIDTH_DEF    = 3;

  typedef enum logic [FAULT_ADDR_WIDTH_DEF-1:0] {
    F_NONE = 3'd0,
    F_BUS  = 3'd1
  } fault_e;

  typedef enum logic {
    CONV_MAIN      = 1'b0,
    CONV_INTERRUPT = 1'b1
  } conveyor_e;

endpackage

// File: rtl/conveyor_read_dispatch_if.sv
// Request, memory-bus and slot-write signals of the read dispatcher.
// slave is the dispatcher's view; master is the surrounding system's view.
interface conveyor_read_dispatch_if
  import conveyor_read_dispatch_pkg::*;
#(
  parameter int WORD_WIDTH          = WORD_WIDTH_DEF,
  parameter int CONVEYOR_ADDR_WIDTH = CONVEYOR_ADDR_WIDTH_DEF,
  parameter int FAULT_ADDR_WIDTH    = FAULT_ADDR_WIDTH_DEF
);
  logic                                       req_valid;
  logic                                       req_ready;
  logic [WORD_WIDTH-1:0]                      req_addr;
  logic                                       req_conveyor;
  logic [CONVEYOR_ADDR_WIDTH-1:0]             req_slot;

  logic                                       mem_req_valid;
  logic                                       mem_req_ready;
  logic [WORD_WIDTH-1:0]                      mem_req_addr;
  logic                                       mem_resp_valid;
  logic [WORD_WIDTH-1:0]                      mem_resp_data;
  logic                                       mem_resp_error;

  logic                                       wr_valid;
  logic                                       wr_conveyor;
  logic [CONVEYOR_ADDR_WIDTH-1:0]             wr_slot;
  logic [1+FAULT_ADDR_WIDTH+WORD_WIDTH-1:0]   wr_word;

  modport slave (
    input  req_valid, req_addr, req_conveyor, req_slot,
    input  mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_error,
    output req_ready, mem_req_valid, mem_req_addr,
    output wr_valid, wr_conveyor, wr_slot, wr_word
  );

  modport master (
    output req_valid, req_addr, req_conveyor, req_slot,
    output mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_error,
    input  req_ready, mem_req_valid, mem_req_addr,
    input  wr_valid, wr_conveyor, wr_slot, wr_word
  );

endinterface

// File: rtl/conveyor_read_dispatch_tag_fifo.sv
// Synchronous FIFO holding {conveyor, slot} tags of reads in flight.
// Full/empty derive from the occupancy count so pointers can simply wrap.
module conveyor_read_dispatch_tag_fifo #(
  parameter int WIDTH      = 5,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      din_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      dout_o,
  output logic [ADDR_WIDTH:0]   count_o
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  push_ok, pop_ok;

  assign push_ok = push_i && (count_q != (ADDR_WIDTH+1)'(DEPTH));
  assign pop_ok  = pop_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(push_ok);
    rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(pop_ok);
    count_d  = count_q + (ADDR_WIDTH+1)'(push_ok) - (ADDR_WIDTH+1)'(pop_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Tag storage needs no reset: entries are only read once counted as valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/conveyor_read_dispatch.sv
// Issues tagged reads in order on a valid/ready bus and turns each in-order
// response into a one-cycle slot write addressed to the tagged conveyor slot.
module conveyor_read_dispatch
  import conveyor_read_dispatch_pkg::*;
#(
  parameter int WORD_WIDTH          = WORD_WIDTH_DEF,
  parameter int CONVEYOR_ADDR_WIDTH = CONVEYOR_ADDR_WIDTH_DEF,
  parameter int TAG_FIFO_ADDR_WIDTH = TAG_FIFO_ADDR_WIDTH_DEF,
  parameter int FAULT_ADDR_WIDTH    = FAULT_ADDR_WIDTH_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  conveyor_read_dispatch_if.slave        bus,
  output logic [TAG_FIFO_ADDR_WIDTH:0]   outstanding_o,
  output logic                           protocol_error_o
);
  localparam int DEPTH   = 1 << TAG_FIFO_ADDR_WIDTH;
  localparam int TAG_W   = 1 + CONVEYOR_ADDR_WIDTH;
  localparam int SLOT_W  = 1 + FAULT_ADDR_WIDTH + WORD_WIDTH;

  logic [TAG_FIFO_ADDR_WIDTH:0]   count;
  logic [TAG_W-1:0]               tag_head;
  logic                           tags_full, tags_empty;
  logic                           req_fire, resp_pop;

  logic                           mem_req_valid_q, mem_req_valid_d;
  logic [WORD_WIDTH-1:0]          mem_req_addr_q, mem_req_addr_d;
  logic                           wr_valid_q, wr_valid_d;
  logic                           wr_conveyor_q, wr_conveyor_d;
  logic [CONVEYOR_ADDR_WIDTH-1:0] wr_slot_q, wr_slot_d;
  logic [SLOT_W-1:0]              wr_word_q, wr_word_d;
  logic                           protocol_error_q, protocol_error_d;

  assign tags_full  = (count == (TAG_FIFO_ADDR_WIDTH+1)'(DEPTH));
  assign tags_empty = (count == '0);

  // Registered count keeps req_ready free of any response in the same cycle.
  assign bus.req_ready = !tags_full && (!mem_req_valid_q || bus.mem_req_ready);
  assign req_fire      = bus.req_valid && bus.req_ready;
  assign resp_pop      = bus.mem_resp_valid && !tags_empty;

  conveyor_read_dispatch_tag_fifo #(
    .WIDTH      (TAG_W),
    .ADDR_WIDTH (TAG_FIFO_ADDR_WIDTH)
  ) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (req_fire),
    .din_i   ({bus.req_conveyor, bus.req_slot}),
    .pop_i   (resp_pop),
    .dout_o  (tag_head),
    .count_o (count)
  );

  always_comb begin
    mem_req_valid_d  = mem_req_valid_q;
    mem_req_addr_d   = mem_req_addr_q;
    wr_valid_d       = resp_pop;
    wr_conveyor_d    = wr_conveyor_q;
    wr_slot_d        = wr_slot_q;
    wr_word_d        = wr_word_q;
    protocol_error_d = protocol_error_q || (bus.mem_resp_valid && tags_empty);

    if (req_fire) begin
      mem_req_valid_d = 1'b1;
      mem_req_addr_d  = bus.req_addr;
    end else if (bus.mem_req_ready) begin
      mem_req_valid_d = 1'b0;
    end

    if (resp_pop) begin
      wr_conveyor_d = tag_head[CONVEYOR_ADDR_WIDTH];
      wr_slot_d     = tag_head[CONVEYOR_ADDR_WIDTH-1:0];
      // A bus error replaces the data with zero so consumers see only the fault.
      if (bus.mem_resp_error)
        wr_word_d = {1'b1, FAULT_ADDR_WIDTH'(F_BUS), {WORD_WIDTH{1'b0}}};
      else
        wr_word_d = {1'b1, FAULT_ADDR_WIDTH'(F_NONE), bus.mem_resp_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req_valid_q  <= 1'b0;
      mem_req_addr_q   <= '0;
      wr_valid_q       <= 1'b0;
      wr_conveyor_q    <= 1'b0;
      wr_slot_q        <= '0;
      wr_word_q        <= '0;
      protocol_error_q <= 1'b0;
    end else begin
      mem_req_valid_q  <= mem_req_valid_d;
      mem_req_addr_q   <= mem_req_addr_d;
      wr_valid_q       <= wr_valid_d;
      wr_conveyor_q    <= wr_conveyor_d;
      wr_slot_q        <= wr_slot_d;
      wr_word_q        <= wr_word_d;
      protocol_error_q <= protocol_error_d;
    end
  end

  assign bus.mem_req_valid = mem_req_valid_q;
  assign bus.mem_req_addr  = mem_req_addr_q;
  assign bus.wr_valid      = wr_valid_q;
  assign bus.wr_conveyor   = wr_conveyor_q;
  assign bus.wr_slot       = wr_slot_q;
  assign bus.wr_word       = wr_word_q;
  assign outstanding_o     = count;
  assign protocol_error_o  = protocol_error_q;

endmodule

// File: tb/tb_conveyor_read_dispatch.sv
// Directed scenarios plus randomized traffic against a queue-based model of
// the dispatcher's request, issue and write-back rules.
module tb_conveyor_read_dispatch;
  import conveyor_read_dispatch_pkg::*;

  localparam int WW = 32, CW = 4, AW = 2, FW = 3, DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [AW:0] outstanding;
  logic        protocol_error;

  always #5 clk = ~clk;

  conveyor_read_dispatch_if #(.WORD_WIDTH(WW), .CONVEYOR_ADDR_WIDTH(CW), .FAULT_ADDR_WIDTH(FW)) bus ();

  conveyor_read_dispatch #(
    .WORD_WIDTH(WW), .CONVEYOR_ADDR_WIDTH(CW), .TAG_FIFO_ADDR_WIDTH(AW), .FAULT_ADDR_WIDTH(FW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .bus              (bus.slave),
    .outstanding_o    (outstanding),
    .protocol_error_o (protocol_error)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: reads accepted but unanswered, the pending bus issue,
  // reads already handed to the bus, and the last slot write produced.
  logic [4:0]  m_tags[$];
  logic        m_iss_v;
  logic [31:0] m_iss_addr;
  int          m_on_bus;
  logic        m_perr;
  logic        m_wr_v, m_wr_conv;
  logic [3:0]  m_wr_slot;
  logic [35:0] m_wr_word;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_tags.delete();
    m_iss_v = 0; m_iss_addr = '0; m_on_bus = 0; m_perr = 0;
    m_wr_v = 0; m_wr_conv = 0; m_wr_slot = '0; m_wr_word = '0;
  endtask

  task automatic check_outputs();
    check_eq("mem_req_valid", bus.mem_req_valid, m_iss_v);
    check_eq("mem_req_addr", bus.mem_req_addr, m_iss_addr);
    check_eq("wr_valid", bus.wr_valid, m_wr_v);
    check_eq("wr_conveyor", bus.wr_conveyor, m_wr_conv);
    check_eq("wr_slot", bus.wr_slot, m_wr_slot);
    check_eq("wr_word", bus.wr_word, m_wr_word);
    check_eq("outstanding", outstanding, m_tags.size());
    check_eq("protocol_error", protocol_error, m_perr);
  endtask

  task automatic drive_idle();
    bus.req_valid = 0; bus.req_addr = '0; bus.req_conveyor = 0; bus.req_slot = '0;
    bus.mem_req_ready = 0; bus.mem_resp_valid = 0; bus.mem_resp_data = '0; bus.mem_resp_error = 0;
  endtask

  // One clock: drive inputs, check req_ready, advance the model, check outputs.
  task automatic cycle(input logic rv, input logic [31:0] addr, input logic conv,
                       input logic [3:0] slot, input logic mrr, input logic respv,
                       input logic [31:0] data, input logic err);
    logic rr, fire, hs, pop;
    logic [4:0] tag;
    bus.req_valid = rv; bus.req_addr = addr; bus.req_conveyor = conv; bus.req_slot = slot;
    bus.mem_req_ready = mrr; bus.mem_resp_valid = respv;
    bus.mem_resp_data = data; bus.mem_resp_error = err;
    #1;
    rr = (m_tags.size() < DEPTH) && (!m_iss_v || mrr);
    check_eq("req_ready", bus.req_ready, rr);
    fire = rv && rr;
    hs   = m_iss_v && mrr;
    pop  = respv && (m_tags.size() > 0);
    if (respv && m_tags.size() == 0) m_perr = 1;
    m_wr_v = pop;
    if (pop) begin
      tag = m_tags.pop_front();
      m_wr_conv = tag[4];
      m_wr_slot = tag[3:0];
      m_wr_word = err ? {1'b1, F_BUS, 32'd0} : {1'b1, F_NONE, data};
      if (m_on_bus > 0) m_on_bus--;
    end
    if (fire) m_tags.push_back({conv, slot});
    if (hs) m_on_bus++;
    if (fire) begin
      m_iss_v = 1; m_iss_addr = addr;
    end else if (hs) begin
      m_iss_v = 0;
    end
    @(posedge clk); #1;
    check_outputs();
  endtask

  task automatic idle_cycle(input logic mrr);
    cycle(0, 32'h0, 0, 4'h0, mrr, 0, 32'h0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 24 && m_tags.size() > 0; i++)
      cycle(0, 32'h0, 0, 4'h0, 1, (m_on_bus > 0), $urandom, 0);
  endtask

  task automatic apply_reset();
    drive_idle();
    rst_n = 0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    check_outputs();
  endtask

  initial begin
    rst_n = 0;
    drive_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    @(posedge clk); #1;
    check_outputs();
    check_eq("reset_outstanding", outstanding, 0);
    check_eq("reset_perr", protocol_error, 0);

    // Single read, response two cycles after the bus handshake
    cycle(1, 32'h100, 0, 4'd15, 1, 0, 32'h0, 0);
    check_eq("single_addr", bus.mem_req_addr, 32'h100);
    check_eq("single_outstanding1", outstanding, 1);
    idle_cycle(1);
    idle_cycle(1);
    cycle(0, 32'h0, 0, 4'h0, 1, 1, 32'hDEADBEEF, 0);
    check_eq("single_wr_valid", bus.wr_valid, 1);
    check_eq("single_wr_slot", bus.wr_slot, 15);
    check_eq("single_wr_conv", bus.wr_conveyor, 0);
    check_eq("single_wr_word", bus.wr_word, {1'b1, F_NONE, 32'hDEADBEEF});
    check_eq("single_outstanding0", outstanding, 0);
    idle_cycle(1);
    check_eq("single_wr_pulse", bus.wr_valid, 0);

    // Fill the tag FIFO, then a response coinciding with a blocked request
    for (int i = 0; i < 4; i++)
      cycle(1, 32'h200 + 32'(i * 4), i[0], 4'(3 + i), 1, 0, 32'h0, 0);
    check_eq("fill_outstanding", outstanding, 4);
    cycle(1, 32'h300, 1, 4'd9, 1, 1, 32'h12345678, 0);
    check_eq("fill_wr_slot", bus.wr_slot, 3);
    cycle(1, 32'h300, 1, 4'd9, 1, 0, 32'h0, 0);
    drain();

    // Bus stall: the issued address must hold while the bus refuses it
    cycle(1, 32'hA0A0, 1, 4'd2, 0, 0, 32'h0, 0);
    for (int i = 0; i < 3; i++)
      cycle(1, 32'hB000 + 32'(i), 0, 4'd5, 0, 0, 32'h0, 0);
    check_eq("stall_addr", bus.mem_req_addr, 32'hA0A0);
    idle_cycle(1);
    drain();

    // Bus error response
    cycle(1, 32'h400, 1, 4'd7, 1, 0, 32'h0, 0);
    idle_cycle(1);
    cycle(0, 32'h0, 0, 4'h0, 1, 1, 32'hFFFF_FFFF, 1);
    check_eq("error_word", bus.wr_word, {1'b1, F_BUS, 32'd0});
    check_eq("error_slot", bus.wr_slot, 7);
    check_eq("error_conv", bus.wr_conveyor, 1);
    check_eq("error_popped", outstanding, 0);

    // Spurious response with nothing outstanding
    cycle(0, 32'h0, 0, 4'h0, 1, 1, 32'h55, 0);
    check_eq("spurious_no_write", bus.wr_valid, 0);
    idle_cycle(1);
    idle_cycle(1);
    check_eq("spurious_sticky", protocol_error, 1);

    // Asynchronous reset with three reads in flight
    for (int i = 0; i < 3; i++)
      cycle(1, 32'h600 + 32'(i), 1, 4'(10 + i), 1, 0, 32'h0, 0);
    #2;
    rst_n = 0;
    #1;
    check_eq("areset_mem_req_valid", bus.mem_req_valid, 0);
    check_eq("areset_mem_req_addr", bus.mem_req_addr, 0);
    check_eq("areset_wr_valid", bus.wr_valid, 0);
    check_eq("areset_wr_conv", bus.wr_conveyor, 0);
    check_eq("areset_wr_slot", bus.wr_slot, 0);
    check_eq("areset_wr_word", bus.wr_word, 0);
    check_eq("areset_outstanding", outstanding, 0);
    check_eq("areset_perr", protocol_error, 0);
    drive_idle();
    model_reset();
    @(posedge clk); #3;
    rst_n = 1;
    @(posedge clk); #1;
    check_outputs();
    cycle(0, 32'h0, 0, 4'h0, 1, 1, 32'h77, 0);
    check_eq("post_reset_perr", protocol_error, 1);
    check_eq("post_reset_no_write", bus.wr_valid, 0);
    apply_reset();

    // Randomized traffic with increasing bus backpressure
    for (int phase = 0; phase < 3; phase++) begin
      for (int i = 0; i < 600; i++) begin
        logic rv, mrr, respv;
        rv    = ($urandom_range(0, 3) != 0);
        mrr   = ($urandom_range(0, 3) >= phase);
        respv = (m_on_bus > 0) && ($urandom_range(0, 2) != 0);
        cycle(rv, $urandom, 1'($urandom), 4'($urandom), mrr, respv, $urandom,
              ($urandom_range(0, 3) == 0));
      end
      drain();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
